latch_read_sync: RTL and testbench

- Clocked reader for an external level-sensitive D-latch register.
- The writer drives the latch's data and enable asynchronously.
- This block detects each close of the latch (enable high then low), captures the now-stable latch output into the Clk domain, and presents it on a valid/ready port.
- It sits between latch-based storage and synchronous consumer logic. It flags writes that arrive before the previous value was read.

---
 rtl/latch_read_sync.sv | 116 +++++++++++
 tb/tb_latch_read_sync.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_read_sync.sv
// Clocked reader for an external level-sensitive latch: detects each latch close,
// captures the settled latch output and offers it on a valid/ready port.
// Optional build macro LATCH_READ_PARITY_EN adds rd_parity registered alongside rd_data.
//
// state | meaning
// IDLE  | latch closed, nothing unread
// OPEN  | latch transparent, waiting for the close to capture
// VALID | captured value waiting for the consumer
module latch_read_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             reset_b,
    input  logic [WIDTH-1:0] latch_q,
    input  logic             latch_en,
    input  logic             rd_ready,
    input  logic             overrun_clr,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             overrun
`ifdef LATCH_READ_PARITY_EN
    ,
    output logic             rd_parity
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   en_s_d_q;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   overrun_q, overrun_d;
    logic                   en_s;
    logic                   rise;
`ifdef LATCH_READ_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    assign en_s = sync_q[SYNC_STAGES-1];
    assign rise = en_s & ~en_s_d_q;

    always_ff @(posedge Clk or negedge reset_b) begin
        if (!reset_b) begin
            sync_q    <= '0;
            en_s_d_q  <= 1'b0;
            state_q   <= IDLE;
            data_q    <= '0;
            overrun_q <= 1'b0;
`ifdef LATCH_READ_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], latch_en};
            en_s_d_q  <= en_s;
            state_q   <= state_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
`ifdef LATCH_READ_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        overrun_d = overrun_q;
`ifdef LATCH_READ_PARITY_EN
        parity_d  = parity_q;
`endif
        // Clear first so a same-cycle set below takes priority.
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (en_s) begin
                    state_d = OPEN;
                end
            end
            OPEN: begin
                if (!en_s) begin
                    data_d  = latch_q;
                    state_d = VALID;
`ifdef LATCH_READ_PARITY_EN
                    parity_d = ^latch_q;
`endif
                end
            end
            VALID: begin
                if (rd_ready) begin
                    state_d = en_s ? OPEN : IDLE;
                end else if (rise) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_valid = (state_q == VALID);
    assign rd_data  = data_q;
    assign overrun  = overrun_q;
`ifdef LATCH_READ_PARITY_EN
    assign rd_parity = parity_q;
`endif

endmodule

// File: tb/tb_latch_read_sync.sv
// Directed self-checking bench for latch_read_sync (WIDTH=8, SYNC_STAGES=2).
// Builds with or without LATCH_READ_PARITY_EN.
module tb_latch_read_sync;

    logic       Clk;
    logic       reset_b;
    logic [7:0] latch_q;
    logic       latch_en;
    logic       rd_ready;
    logic       overrun_clr;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       overrun;
`ifdef LATCH_READ_PARITY_EN
    logic       rd_parity;
`endif

    int checks = 0;
    int errors = 0;

    latch_read_sync #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .Clk         (Clk),
        .reset_b     (reset_b),
        .latch_q     (latch_q),
        .latch_en    (latch_en),
        .rd_ready    (rd_ready),
        .overrun_clr (overrun_clr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .overrun     (overrun)
`ifdef LATCH_READ_PARITY_EN
        ,
        .rd_parity   (rd_parity)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Open the latch with value v for five cycles, leave it closed on return.
    task automatic open_latch(input logic [7:0] v);
        latch_q  = v;
        latch_en = 1'b1;
        repeat (5) tick();
        latch_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_b = 1'b0; latch_en = 1'b0; latch_q = 8'h00;
        rd_ready = 1'b0; overrun_clr = 1'b0;
        #3;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: valid=%b data=%h overrun=%b, want 0/00/0", rd_valid, rd_data, overrun);
        end
        repeat (2) tick();
        reset_b = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_single_write();
        rd_ready = 1'b1;
        open_latch(8'hA5);
        tick();  // edge k
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_k: valid=%b want 0", rd_valid); end
        tick();  // edge k+1
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_k1: valid=%b want 0", rd_valid); end
        tick();  // edge k+2
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
            errors++; $display("FAIL single_k2: valid=%b data=%h want 1/a5", rd_valid, rd_data);
        end
        tick();  // edge k+3: handshake done
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_k3: valid=%b want 0", rd_valid); end
        repeat (4) tick();
        checks++;
        if (rd_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL single_idle: valid=%b overrun=%b want 0/0", rd_valid, overrun);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        rd_ready = 1'b0;
        open_latch(8'h3C);
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
                errors++; $display("FAIL bp_hold[%0d]: valid=%b data=%h want 1/3c", i, rd_valid, rd_data);
            end
            tick();
        end
        rd_ready = 1'b1;
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL bp_release: valid=%b want 0", rd_valid); end
        rd_ready = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_overrun();
        rd_ready = 1'b0;
        open_latch(8'h11);
        repeat (3) tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h11 || overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_capture: valid=%b data=%h ovr=%b want 1/11/0", rd_valid, rd_data, overrun);
        end
        latch_q  = 8'h22;
        latch_en = 1'b1;
        repeat (4) tick();
        checks++;
        if (overrun !== 1'b1 || rd_data !== 8'h11 || rd_valid !== 1'b1) begin
            errors++; $display("FAIL ovr_set: ovr=%b data=%h valid=%b want 1/11/1", overrun, rd_data, rd_valid);
        end
        latch_en = 1'b0;
        repeat (4) tick();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0 || rd_data !== 8'h11) begin
            errors++; $display("FAIL ovr_clear: ovr=%b data=%h want 0/11", overrun, rd_data);
        end
        // After two edges en_s is high and the rise is live; clear in the same cycle.
        latch_en = 1'b1;
        repeat (2) tick();
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: ovr=%b want 1", overrun); end
        latch_en = 1'b0;
        repeat (4) tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_cleanup: valid=%b ovr=%b want 0/0", rd_valid, overrun);
        end
        repeat (2) tick();
    endtask

    task automatic test_read_during_open();
        rd_ready = 1'b0;
        open_latch(8'h55);
        repeat (3) tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h55) begin
            errors++; $display("FAIL rdo_first: valid=%b data=%h want 1/55", rd_valid, rd_data);
        end
        latch_q  = 8'h66;
        latch_en = 1'b1;
        repeat (2) tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL rdo_handshake: valid=%b ovr=%b want 0/0", rd_valid, overrun);
        end
        repeat (3) tick();
        latch_en = 1'b0;
        repeat (3) tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h66 || overrun !== 1'b0) begin
            errors++; $display("FAIL rdo_second: valid=%b data=%h ovr=%b want 1/66/0", rd_valid, rd_data, overrun);
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_release_open();
        reset_b  = 1'b0;
        latch_en = 1'b1;
        latch_q  = 8'h0F;
        tick();
        reset_b = 1'b1;
        repeat (5) tick();
        latch_en = 1'b0;
        repeat (3) tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h0F) begin
            errors++; $display("FAIL rel_capture: valid=%b data=%h want 1/0f", rd_valid, rd_data);
        end
`ifdef LATCH_READ_PARITY_EN
        checks++;
        if (rd_parity !== 1'b0) begin errors++; $display("FAIL rel_parity0: parity=%b want 0", rd_parity); end
`endif
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        open_latch(8'h07);
        repeat (3) tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h07) begin
            errors++; $display("FAIL rel_second: valid=%b data=%h want 1/07", rd_valid, rd_data);
        end
`ifdef LATCH_READ_PARITY_EN
        checks++;
        if (rd_parity !== 1'b1) begin errors++; $display("FAIL rel_parity1: parity=%b want 1", rd_parity); end
`endif
    endtask

    // Entered with 8'h07 unread; reset lands mid-cycle, away from any edge.
    task automatic test_reset_midop();
        tick();
        #2;
        reset_b = 1'b0;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || overrun !== 1'b0) begin
            errors++; $display("FAIL reset_midop: valid=%b data=%h ovr=%b want 0/00/0", rd_valid, rd_data, overrun);
        end
        tick();
        reset_b = 1'b1;
        repeat (4) tick();
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: valid=%b want 0", rd_valid); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_backpressure();
        test_overrun();
        test_read_during_open();
        test_reset_release_open();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
